// File: rtl/countdown_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | countdown_display_ctrl: 0-59 s BCD countdown driving two active-low 7-seg   |
// | digits. Revision: 1.0                                                        |
// +----------------------------------------------------------------------------+
module countdown_display_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int MAX_VAL  = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] SW,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  output logic       done,
  output logic       running,
  output logic [6:0] HEX_0,
  output logic [6:0] HEX_1
);

  localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]    MAX_V     = 7'(MAX_VAL);
  localparam logic [6:0]    SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    hex0_q, hex0_d;
  logic [6:0]    hex1_q, hex1_d;

  logic [7:0]    load_bcd;
  logic          count_zero;
  logic          last_step;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Clamp, then peel off tens by repeated subtraction; nine passes cover 0..99.
  function automatic logic [7:0] to_bcd(input logic [5:0] sw);
    logic [6:0] r;
    logic [3:0] t;
    r = ({1'b0, sw} > MAX_V) ? MAX_V : {1'b0, sw};
    t = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  assign load_bcd   = to_bcd(SW);
  assign count_zero = (tens_q == 4'd0) && (units_q == 4'd0);
  assign last_step  = (tens_q == 4'd0) && (units_q == 4'd1);

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    presc_d = presc_q;
    hex0_d  = seg7(units_q);
    hex1_d  = seg7(tens_q);

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          tens_d  = load_bcd[7:4];
          units_d = load_bcd[3:0];
        end else if (start && !count_zero) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end

      ST_RUN: begin
        if (load) begin
          tens_d  = load_bcd[7:4];
          units_d = load_bcd[3:0];
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (presc_q == TICK_LAST) begin
          presc_d = '0;
          if (units_q == 4'd0) begin
            units_d = 4'd9;
            tens_d  = tens_q - 4'd1;
          end else begin
            units_d = units_q - 4'd1;
          end
          if (last_step) begin
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      ST_PAUSE: begin
        if (load) begin
          tens_d  = load_bcd[7:4];
          units_d = load_bcd[3:0];
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_RUN;
        end else if (start) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end

      ST_DONE: begin
        if (load) begin
          tens_d  = load_bcd[7:4];
          units_d = load_bcd[3:0];
          presc_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      presc_q <= '0;
      hex0_q  <= SEG_ZERO;
      hex1_q  <= SEG_ZERO;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      presc_q <= presc_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
    end
  end

  assign done    = (state_q == ST_DONE);
  assign running = (state_q == ST_RUN);
  assign HEX_0   = hex0_q;
  assign HEX_1   = hex1_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_countdown_display_ctrl: directed bench, TICK_DIV=4, MAX_VAL=59.          |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_countdown_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0011000;

  logic       clk;
  logic       rst_n;
  logic [5:0] SW;
  logic       load;
  logic       start;
  logic       pause;
  logic       done;
  logic       running;
  logic [6:0] HEX_0;
  logic [6:0] HEX_1;

  int n_checks;
  int n_fail;

  countdown_display_ctrl #(
    .TICK_DIV(4),
    .MAX_VAL (59)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SW     (SW),
    .load   (load),
    .start  (start),
    .pause  (pause),
    .done   (done),
    .running(running),
    .HEX_0  (HEX_0),
    .HEX_1  (HEX_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] e1, input logic [6:0] e0);
    check({tag, "_hex1"}, HEX_1, e1);
    check({tag, "_hex0"}, HEX_0, e0);
  endtask

  task automatic do_load(input logic [5:0] v);
    SW   = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b1;
    SW    = 6'd0;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_done", {6'd0, done}, 7'd0);
    check("rst_running", {6'd0, running}, 7'd0);
    check_hex("rst", S0, S0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // 37 -> "37"
    do_load(6'd37);
    check("ld37_done", {6'd0, done}, 7'd0);
    check("ld37_running", {6'd0, running}, 7'd0);
    tick(1);
    check_hex("ld37", S3, S7);

    // clamp 63 -> 59
    do_load(6'd63);
    tick(1);
    check_hex("ld63", S5, S9);

    // exact multiple of ten
    do_load(6'd10);
    tick(1);
    check_hex("ld10", S1, S0);

    // SW change without load has no effect
    SW = 6'd42;
    tick(2);
    check_hex("sw_noload", S1, S0);

    // pause in IDLE ignored
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    check("idle_pause", {6'd0, running}, 7'd0);

    // 20 -> 19 -> 18
    do_load(6'd20);
    tick(1);
    check_hex("ld20", S2, S0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("run20_running", {6'd0, running}, 7'd1);
    tick(4);
    check_hex("run20_e4", S2, S0);
    tick(1);
    check_hex("run20_e5", S1, S9);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("run20_start_ign", {6'd0, running}, 7'd1);
    tick(2);
    check_hex("run20_e8", S1, S9);
    tick(1);
    check_hex("run20_e9", S1, S8);

    // load during RUN returns to IDLE
    do_load(6'd3);
    check("ld3_running", {6'd0, running}, 7'd0);
    tick(1);
    check_hex("ld3", S0, S3);

    // 3 with pause holding prescaler fraction
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    check("pause_running", {6'd0, running}, 7'd0);
    check("pause_done", {6'd0, done}, 7'd0);
    tick(10);
    check_hex("paused", S0, S3);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    check("resume_running", {6'd0, running}, 7'd1);
    tick(2);
    check_hex("resume_r2", S0, S3);
    tick(1);
    check_hex("resume_r3", S0, S2);
    tick(6);
    check("pre_done", {6'd0, done}, 7'd0);
    check("pre_done_running", {6'd0, running}, 7'd1);
    tick(1);
    check("done_set", {6'd0, done}, 7'd1);
    check("done_running", {6'd0, running}, 7'd0);
    tick(1);
    check_hex("done", S0, S0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("done_start_ign", {6'd0, done}, 7'd1);
    check("done_start_run", {6'd0, running}, 7'd0);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    check("done_pause_ign", {6'd0, done}, 7'd1);

    // load from DONE; start with count 00 ignored
    do_load(6'd0);
    check("done_fall", {6'd0, done}, 7'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("zero_start", {6'd0, running}, 7'd0);

    // load and start together -> load only
    SW    = 6'd12;
    load  = 1'b1;
    start = 1'b1;
    tick(1);
    load  = 1'b0;
    start = 1'b0;
    check("ld_st_running", {6'd0, running}, 7'd0);
    tick(1);
    check_hex("ld_st", S1, S2);

    // async reset mid-run at 45
    do_load(6'd45);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    check("r45_running", {6'd0, running}, 7'd1);
    check_hex("r45", S4, S5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_running", {6'd0, running}, 7'd0);
    check("arst_done", {6'd0, done}, 7'd0);
    check_hex("arst", S0, S0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("arst_zero_start", {6'd0, running}, 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/countdown_display_ctrl.md
Name: countdown_display_ctrl

Overview:
- Sequencer for the two-digit seven-segment display datapath.
- Loads a 0–59 second preset from the 6-bit switch bank and counts down in BCD once per tick.
- Drives active-low segment codes on HEX_0 (units) and HEX_1 (tens), and flags completion.
- Sits between debounced board buttons/switches and the display pins.

Parameters:
- TICK_DIV, 50000000, clk cycles per count step (1 s at 50 MHz); minimum 2.
- MAX_VAL, 59, preset ceiling; must be ≤99.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SW  input  6  preset value, unsigned binary.
- load  input  1  one-cycle pulse; latch SW as the count.
- start  input  1  one-cycle pulse; begin countdown.
- pause  input  1  one-cycle pulse; toggle RUN/PAUSE.
- done  output  1  high while in DONE.
- running  output  1  high while in RUN.
- HEX_0  output  7  units digit segments {g,f,e,d,c,b,a}, active-low, registered.
- HEX_1  output  7  tens digit segments, same encoding, registered.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; tens=0, units=0, prescaler=0.
  - done=0, running=0.
  - HEX_0=HEX_1=7'b1000000 ("00").
- Segment table, active-low (digit:code):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001.
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0011000.
  - Other codes: 1111111 (blank).
- HEX outputs are registered from tens/units and lag the count by exactly 1 cycle.
- Load conversion:
  - v = min(SW, MAX_VAL).
  - Binary-to-BCD by comparison/subtraction: tens = v/10, units = v%10. Exact multiples of 10 map correctly, e.g. 20 gives tens=2, units=0.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - load: latch preset; stay IDLE.
  - start with count≠00: go RUN, clear prescaler.
  - start with count=00: ignored.
  - pause: ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and the count decrements the same edge.
  - BCD decrement: units>0 → units-1; units=0 → units=9, tens-1.
  - When the decrement produces 00: go DONE on that same edge.
  - pause: go PAUSE; prescaler held (fraction retained).
  - load: latch preset, go IDLE, clear prescaler.
  - start: ignored.
- PAUSE:
  - pause: back to RUN, prescaler resumes from its held value.
  - load: latch preset, go IDLE.
  - start: go RUN, prescaler cleared.
- DONE:
  - done=1, count holds 00.
  - load: latch preset, go IDLE, done falls next cycle.
  - start and pause: ignored.
- Simultaneous pulses: priority is load > pause > start, so only one action per cycle.
- First decrement occurs TICK_DIV cycles after the start edge.
- From preset N, DONE is reached N·TICK_DIV cycles after the start edge.
- running=1 exactly in RUN.
- SW changes have no effect without load.
- Reset asserted mid-count returns to the reset values immediately, without waiting for clk.

Test Plan (TICK_DIV=4, MAX_VAL=59):
- Reset, then SW=37 with load → tens=3, units=7; next cycle HEX_1=0110000, HEX_0=1111000; done=0.
- SW=63 with load → count 59, HEX_1=0010010, HEX_0=0011000 (clamp).
- Load 20, start → at +4 cycles count=19, at +8 count=18; units wrap 0→9 with tens decrement exercised.
- Load 3, start, pause at +2 cycles for 10 cycles, resume → decrement lands 2 cycles after resume; done=1 at total run time 12 cycles; HEX show "00"; further start is ignored.
- In IDLE with count 00, start → stays IDLE, running=0. Load and start in the same cycle → load only, state IDLE.
- rst_n low mid-RUN at count 45 → immediately done=0, running=0, count=00, HEX both 1000000.
